// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and imem.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: handshaked imem requests, stall hold buffer, branch flush/redirect.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = '0,
    parameter int unsigned IMEM_DEPTH = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [31:0]       branch_target,
    fetch_sequencer_if.master imem,
    output logic [63:0]       IF_ID,
    output logic              if_id_valid,
    output logic [31:0]       fetch_count
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pc_next;
    logic [31:0] hold_pc_q, hold_pc_d, hold_data_q, hold_data_d;
    logic [31:0] addr_d, count_d;
    logic [63:0] ifid_d;
    logic        req_d, valid_d;
    logic        ack, slot_free;

    assign ack       = imem.imem_ack && imem.imem_req;
    assign slot_free = !if_id_valid || !stall;
    assign pc_next   = (pc_q == 32'(IMEM_DEPTH - 1)) ? '0 : pc_q + 32'd1;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = imem.imem_req;
        addr_d      = imem.imem_addr;
        ifid_d      = IF_ID;
        valid_d     = if_id_valid && stall;
        count_d     = fetch_count;
        hold_pc_d   = hold_pc_q;
        hold_data_d = hold_data_q;

        if (branch_flag) begin
            pc_d    = branch_target;
            valid_d = 1'b0;
            // An unanswered request must still complete, so it is kept on the bus and drained in DROP.
            if ((state_q == FETCH || state_q == DROP) && !ack) begin
                state_d = DROP;
            end else begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = branch_target;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
                FETCH: begin
                    if (ack) begin
                        pc_d = pc_next;
                        if (slot_free) begin
                            ifid_d  = {imem.imem_addr, imem.imem_data};
                            valid_d = 1'b1;
                            count_d = fetch_count + 32'd1;
                            addr_d  = pc_next;
                        end else begin
                            hold_pc_d   = imem.imem_addr;
                            hold_data_d = imem.imem_data;
                            req_d       = 1'b0;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        ifid_d  = {hold_pc_q, hold_data_q};
                        valid_d = 1'b1;
                        count_d = fetch_count + 32'd1;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = FETCH;
                    end
                end
                DROP: begin
                    if (ack) begin
                        addr_d  = pc_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            hold_pc_q      <= '0;
            hold_data_q    <= '0;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= RESET_PC;
            IF_ID          <= '0;
            if_id_valid    <= 1'b0;
            fetch_count    <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            hold_pc_q      <= hold_pc_d;
            hold_data_q    <= hold_data_d;
            imem.imem_req  <= req_d;
            imem.imem_addr <= addr_d;
            IF_ID          <= ifid_d;
            if_id_valid    <= valid_d;
            fetch_count    <= count_d;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: random-wait memory model, program-order reference stream, directed corner cases.
`timescale 1ns/1ps
module tb_fetch_sequencer;
    localparam int unsigned DEPTH = 128;
    localparam logic [31:0] RPC   = 32'd0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic [63:0] IF_ID;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    fetch_sequencer_if bus();

    fetch_sequencer #(.RESET_PC(RPC), .IMEM_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .imem(bus), .IF_ID(IF_ID), .if_id_valid(if_id_valid), .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    // Memory: each request is answered after a wait of cur_wait cycles (0 = same cycle).
    logic [31:0] imem [0:DEPTH-1];
    int unsigned mem_max = 0;
    bit          mem_rand = 1'b0;
    int unsigned wcnt = 0, cur_wait = 0;

    assign bus.imem_ack  = bus.imem_req && (wcnt >= cur_wait);
    assign bus.imem_data = imem[bus.imem_addr[6:0]];

    always @(posedge clock) begin
        if (!reset || !bus.imem_req || bus.imem_ack) begin
            wcnt     <= 0;
            cur_wait <= mem_rand ? $urandom_range(mem_max, 0) : mem_max;
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    int unsigned total = 0, bad = 0, pops = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_pc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: instructions leave in program order from the last redirect point.
    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back({model_pc, imem[model_pc[6:0]]});
            model_pc = (model_pc == DEPTH - 1) ? 32'd0 : model_pc + 32'd1;
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        model_pc = pc;
        topup();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (!reset) restart_stream(RPC);
        else if (branch_flag) restart_stream(branch_target);
        topup();
    endtask

    task automatic wait_load(input logic [31:0] c0, output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (fetch_count != c0) got = 1'b1;
        end
    endtask

    task automatic wait_pending();
        for (int i = 0; i < 10 && !(bus.imem_req && !bus.imem_ack); i++) tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, bus.imem_req, 0);
        check({tag, "_addr"}, bus.imem_addr, RPC);
        check({tag, "_ifid"}, IF_ID, 0);
        check({tag, "_valid"}, if_id_valid, 0);
        check({tag, "_count"}, fetch_count, 0);
    endtask

    // Monitor: judges each edge from outputs/inputs sampled before it.
    logic [63:0] p_ifid, e_item;
    logic [31:0] p_count, p_addr;
    logic        p_valid, p_req, p_ack, s_stall, s_branch, s_rstn;
    bit          primed = 1'b0;

    initial begin
        forever begin
            @(negedge clock);
            if (primed && s_rstn) begin
                if (s_branch) begin
                    check("br_count", fetch_count, p_count);
                    check("br_valid", if_id_valid, 0);
                    check("br_ifid", IF_ID, p_ifid);
                end else if (fetch_count != p_count) begin
                    pops++;
                    check("load_step", fetch_count, p_count + 32'd1);
                    check("load_valid", if_id_valid, 1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL stream: got %h expected none", IF_ID);
                    end else begin
                        e_item = exp_q.pop_front();
                        check("stream", IF_ID, e_item);
                    end
                end else begin
                    check("keep_ifid", IF_ID, p_ifid);
                    check("keep_valid", if_id_valid, p_valid && s_stall);
                end
                if (p_req && !p_ack) begin
                    check("req_hold", bus.imem_req, 1);
                    check("addr_hold", bus.imem_addr, p_addr);
                end
            end
            p_ifid   = IF_ID;
            p_count  = fetch_count;
            p_addr   = bus.imem_addr;
            p_valid  = if_id_valid;
            p_req    = bus.imem_req;
            p_ack    = bus.imem_ack;
            s_stall  = stall;
            s_branch = branch_flag;
            s_rstn   = reset;
            primed   = 1'b1;
        end
    end

    initial begin
        logic [63:0] snap;
        logic [31:0] c0, nk, pend, last;
        bit          got, wrap_ok;

        for (int unsigned i = 0; i < DEPTH; i++) imem[i] = $urandom;
        imem[0] = 32'h0AAAAAAA;
        imem[1] = 32'h0BBBBBBB;
        imem[2] = 32'h0CCCCCCC;
        restart_stream(RPC);

        // Reset and zero-wait streaming
        repeat (3) tick();
        check_reset_vals("rst");
        reset = 1'b1;
        tick();
        check("first_req", bus.imem_req, 1);
        tick();
        check("ifid0", IF_ID, 64'h00000000_0AAAAAAA);
        check("valid0", if_id_valid, 1);
        tick();
        check("ifid1", IF_ID, 64'h00000001_0BBBBBBB);
        tick();
        check("ifid2", IF_ID, 64'h00000002_0CCCCCCC);
        check("count3", fetch_count, 3);

        // Two-cycle memory wait: one instruction per three cycles
        mem_max = 2;
        repeat (6) tick();
        c0 = fetch_count;
        repeat (30) tick();
        check("wait2_rate", fetch_count - c0, 10);

        // Stall for four cycles into HOLD, then release
        mem_max = 0;
        repeat (6) tick();
        snap  = IF_ID;
        stall = 1'b1;
        repeat (4) tick();
        check("hold_req", bus.imem_req, 0);
        check("hold_ifid", IF_ID, snap);
        check("hold_valid", if_id_valid, 1);
        stall = 1'b0;
        tick();
        nk = snap[63:32] + 32'd1;
        check("release_ifid", IF_ID, {nk, imem[nk[6:0]]});

        // Branch while a request is waiting: drain into DROP, then fetch target
        mem_max = 2;
        repeat (6) tick();
        wait_pending();
        pend          = bus.imem_addr;
        c0            = fetch_count;
        branch_flag   = 1'b1;
        branch_target = 32'd20;
        tick();
        branch_flag = 1'b0;
        check("drop_valid", if_id_valid, 0);
        check("drop_req", bus.imem_req, 1);
        check("drop_addr", bus.imem_addr, pend);
        wait_load(c0, got);
        check("drop_load", got, 1);
        check("drop_ifid", IF_ID, {32'd20, imem[20]});

        // Branch together with stall while holding
        mem_max = 0;
        repeat (4) tick();
        stall = 1'b1;
        repeat (3) tick();
        c0            = fetch_count;
        branch_flag   = 1'b1;
        branch_target = 32'd40;
        tick();
        branch_flag = 1'b0;
        check("hbr_count", fetch_count, c0);
        check("hbr_valid", if_id_valid, 0);
        stall = 1'b0;
        wait_load(c0, got);
        check("hbr_ifid", IF_ID, {32'd40, imem[40]});
        check("hbr_count1", fetch_count, c0 + 32'd1);

        // Address wrap after the last word
        branch_flag   = 1'b1;
        branch_target = 32'd125;
        tick();
        branch_flag = 1'b0;
        wrap_ok = 1'b0;
        last    = bus.imem_addr;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (last == DEPTH - 1 && bus.imem_addr == 32'd0) wrap_ok = 1'b1;
            last = bus.imem_addr;
        end
        check("wrap", wrap_ok, 1);

        // Random traffic
        mem_rand = 1'b1;
        mem_max  = 3;
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(999, 0) >= 3);
            stall         = ($urandom_range(9, 0) < 3);
            branch_flag   = reset && ($urandom_range(29, 0) == 0);
            branch_target = $urandom_range(DEPTH - 1, 0);
            tick();
        end
        reset       = 1'b1;
        stall       = 1'b0;
        branch_flag = 1'b0;
        repeat (4) tick();
        check("progress", pops > 500, 1);

        // Reset in the middle of a memory wait
        mem_rand = 1'b0;
        mem_max  = 2;
        repeat (5) tick();
        wait_pending();
        reset = 1'b0;
        tick();
        check_reset_vals("midrst");
        reset = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
